// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//
// Passive receiver for a multiplexed 4-digit seven-segment display bus. It
// samples the scanned anode/cathode lines and waits for each digit's dwell to
// settle. It then decodes the settled pattern to a 4-bit symbol code. Once all
// four digits have been captured, it presents the complete frame together with
// a one-cycle valid strobe.
//
// Parameters
//   STABLE_CYCLES  consecutive identical clocks before a digit is captured (>=2)
//   RUN_W          width of the dwell run counter (must hold STABLE_CYCLES-1)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   enables[3:0]   anode selects, active-low, bit i low selects digit i
//   segments[6:0]  cathodes, active-low, {g,f,e,d,c,b,a}
//   digits[15:0]   last complete frame {digit3,digit2,digit1,digit0}
//   frame_valid    one-cycle pulse when digits updates
//   frame_changed  with frame_valid: new frame differs from the previous one
//   glitch_count   saturating count of illegal enable stretches
//   invalid_seen   sticky flag: some captured digit decoded to code F
//
// Symbol codes: 0-9 digits, A = minus, B = blank, F = unrecognised pattern.
// -----------------------------------------------------------------------------
module seg_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned RUN_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  enables,
    input  logic [6:0]  segments,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic [7:0]  glitch_count,
    output logic        invalid_seen
);

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_LEGAL,
        BUS_ILLEGAL
    } bus_class_e;

    localparam logic [10:0]      PREV_RESET = {4'b1111, 7'b1111111};
    // Run value seen on the cycle whose edge completes the dwell.
    localparam logic [RUN_W-1:0] CAP_RUN    = RUN_W'(STABLE_CYCLES - 2);
    localparam logic [RUN_W-1:0] SAT_RUN    = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       CODE_BLANK = 4'hB;
    localparam logic [3:0]       CODE_BAD   = 4'hF;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic bus_class_e classify(input logic [3:0] en);
        bus_class_e cls;
        case (en)
            4'b1111:                             cls = BUS_IDLE;
            4'b1110, 4'b1101, 4'b1011, 4'b0111:  cls = BUS_LEGAL;
            default:                             cls = BUS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'b1000000: code = 4'h0;
            7'b1111001: code = 4'h1;
            7'b0100100: code = 4'h2;
            7'b0110000: code = 4'h3;
            7'b0011001: code = 4'h4;
            7'b0010010: code = 4'h5;
            7'b0000010: code = 4'h6;
            7'b1111000: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0010000: code = 4'h9;
            7'b0111111: code = 4'hA;
            7'b1111111: code = CODE_BLANK;
            default:    code = CODE_BAD;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [10:0]      prev;
    logic [RUN_W-1:0] run;
    logic [3:0]       seen;
    logic [3:0]       hold [4];
    logic             first_pending;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [10:0]      cur;
    bus_class_e       cur_class;
    bus_class_e       prev_class;
    logic             same;
    logic [RUN_W-1:0] run_next;
    logic             capture;
    logic [3:0]       cap_sel;
    logic [3:0]       cap_code;
    logic [3:0]       hold_next [4];
    logic [3:0]       seen_next;
    logic             frame_done;
    logic [15:0]      frame_word;
    logic             glitch_inc;

    always_comb begin
        cur        = {enables, segments};
        cur_class  = classify(enables);
        prev_class = classify(prev[10:7]);
        same       = (cur == prev);
    end

    // Dwell run counter: counts repeats of a legal pattern and parks at
    // STABLE_CYCLES-1 so each run produces a single capture.
    always_comb begin
        run_next = '0;
        capture  = 1'b0;
        if (same && (cur_class == BUS_LEGAL)) begin
            run_next = (run == SAT_RUN) ? SAT_RUN : run + 1'b1;
            capture  = (run == CAP_RUN);
        end
    end

    always_comb begin
        cap_sel  = capture ? ~enables : '0;
        cap_code = decode(segments);
    end

    // Holding registers and seen mask include this cycle's capture so that the
    // fourth capture and frame publication share the same edge.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            hold_next[i] = hold[i];
            if (cap_sel[i]) begin
                hold_next[i] = cap_code;
            end
        end
        seen_next  = seen | cap_sel;
        frame_done = (seen_next == 4'b1111);
        frame_word = {hold_next[3], hold_next[2], hold_next[1], hold_next[0]};
    end

    // Glitch counting on the entry edge of an illegal stretch only.
    always_comb begin
        glitch_inc = (cur_class == BUS_ILLEGAL) && (prev_class != BUS_ILLEGAL)
                     && (glitch_count != 8'hFF);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= PREV_RESET;
            run  <= '0;
        end else begin
            prev <= cur;
            run  <= run_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                hold[i] <= CODE_BLANK;
            end
        end else begin
            seen <= frame_done ? 4'b0000 : seen_next;
            for (int unsigned i = 0; i < 4; i++) begin
                hold[i] <= hold_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits        <= {4{CODE_BLANK}};
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            first_pending <= 1'b1;
        end else begin
            frame_valid   <= frame_done;
            frame_changed <= frame_done && (first_pending || (frame_word != digits));
            if (frame_done) begin
                digits        <= frame_word;
                first_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_count <= '0;
            invalid_seen <= 1'b0;
        end else begin
            if (glitch_inc) begin
                glitch_count <= glitch_count + 8'd1;
            end
            if (capture && (cap_code == CODE_BAD)) begin
                invalid_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_capture
//
// Self-checking bench for seg_scan_capture. Scans are driven as the display
// driver would. Expected frames are queued as each scan starts and compared
// whenever the DUT strobes frame_valid.
// -----------------------------------------------------------------------------
module tb_seg_scan_capture;

    localparam logic [6:0] P1    = 7'b1111001;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P4    = 7'b0011001;
    localparam logic [6:0] P5    = 7'b0010010;
    localparam logic [6:0] PMIN  = 7'b0111111;
    localparam logic [6:0] PBLK  = 7'b1111111;
    localparam logic [6:0] PBAD  = 7'b1111110;
    localparam logic [3:0] IDLE  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  enables = 4'b1111;
    logic [6:0]  segments = 7'b1111111;
    logic [15:0] digits;
    logic        frame_valid;
    logic        frame_changed;
    logic [7:0]  glitch_count;
    logic        invalid_seen;

    int checks   = 0;
    int failures = 0;

    // Expected frames: {frame_changed, digits}
    logic [16:0] exp_q [$];

    seg_scan_capture #(
        .STABLE_CYCLES (4),
        .RUN_W         (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enables       (enables),
        .segments      (segments),
        .digits        (digits),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .glitch_count  (glitch_count),
        .invalid_seen  (invalid_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold one bus value for n clocks; values change just after a rising edge.
    task automatic drive(input logic [3:0] en, input logic [6:0] sg, input int n);
        enables  = en;
        segments = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3, input int dwell);
        drive(4'b1110, p0, dwell);
        drive(4'b1101, p1, dwell);
        drive(4'b1011, p2, dwell);
        drive(4'b0111, p3, dwell);
        drive(IDLE, PBLK, 3);
    endtask

    // Scoreboard monitor: every frame_valid pulse must match the queue head.
    always @(negedge clk) begin
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("frame_digits", {16'd0, digits}, {16'd0, e[15:0]});
                check("frame_changed", {31'd0, frame_changed}, {31'd0, e[16]});
            end
        end else if (frame_changed) begin
            check("changed_without_valid", {31'd0, frame_changed}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_digits", {16'd0, digits}, 32'hBBBB);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_changed", {31'd0, frame_changed}, 32'd0);
        check("rst_glitch", {24'd0, glitch_count}, 32'd0);
        check("rst_invalid", {31'd0, invalid_seen}, 32'd0);
        @(posedge clk); #1;

        // " -15" twice, then "-234"
        exp_q.push_back({1'b1, 16'hBA15});
        scan(P5, P1, PMIN, PBLK, 4);
        check("drain_scan1", exp_q.size(), 32'd0);
        exp_q.push_back({1'b0, 16'hBA15});
        scan(P5, P1, PMIN, PBLK, 4);
        check("drain_scan2", exp_q.size(), 32'd0);
        exp_q.push_back({1'b1, 16'hA234});
        scan(P4, P3, P2, PMIN, 4);
        check("drain_scan3", exp_q.size(), 32'd0);

        // Short dwell: nothing captured, so no frame may appear
        scan(P5, P1, PMIN, PBLK, 3);
        drive(IDLE, PBLK, 4);
        check("short_dwell_digits", {16'd0, digits}, 32'h0000A234);

        // Illegal enables: two separate stretches
        drive(4'b0011, P5, 5);
        drive(IDLE, PBLK, 2);
        drive(4'b0011, P5, 2);
        drive(IDLE, PBLK, 2);
        @(negedge clk);
        check("glitch_count", {24'd0, glitch_count}, 32'd2);
        @(posedge clk); #1;

        // The illegal stretches must not have captured anything: a scan with
        // digits 1..3 only must still leave the frame incomplete.
        drive(4'b1101, P3, 4);
        drive(4'b1011, P2, 4);
        drive(4'b0111, PMIN, 4);
        drive(IDLE, PBLK, 3);
        check("no_capture_in_glitch", exp_q.size(), 32'd0);

        // Invalid pattern on digit 0 completes the frame above
        check("invalid_before", {31'd0, invalid_seen}, 32'd0);
        exp_q.push_back({1'b1, 16'hA23F});
        drive(4'b1110, PBAD, 4);
        drive(IDLE, PBLK, 3);
        check("drain_invalid", exp_q.size(), 32'd0);
        @(negedge clk);
        check("invalid_after", {31'd0, invalid_seen}, 32'd1);
        @(posedge clk); #1;

        // Reset mid-frame discards partial captures
        drive(4'b1110, P5, 4);
        drive(4'b1101, P1, 4);
        drive(4'b1011, PMIN, 4);
        rst = 1'b1;
        drive(IDLE, PBLK, 1);
        rst = 1'b0;
        drive(4'b0111, PBLK, 4);
        drive(IDLE, PBLK, 3);
        @(negedge clk);
        check("midrst_digits", {16'd0, digits}, 32'hBBBB);
        check("midrst_invalid", {31'd0, invalid_seen}, 32'd0);
        check("midrst_glitch", {24'd0, glitch_count}, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 16'hBA15});
        scan(P5, P1, PMIN, PBLK, 4);
        check("drain_after_rst", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
